// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the control-strobe bundle.
// CONTROL_UNIT_JAL_EN adds the JAL opcode handling and the jump strobe.
package riscv_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src;
      logic [1:0] alu_op;
`ifdef CONTROL_UNIT_JAL_EN
      logic       jump;
`endif
   } ctrl_t;

endpackage

// File: rtl/control_unit_status.sv
// Debug status for unsupported opcodes: sticky flag and saturating 8-bit count.
// Updates one clk edge after Illegal is seen; synchronous reset wins; no backpressure.
module control_unit_status
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_illegal,
   output logic       o_seen,
   output logic [7:0] o_count
);

   logic       r_seen;
   logic [7:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seen  <= 1'b0;
         r_count <= 8'd0;
      end else if (i_illegal) begin
         r_seen <= 1'b1;
         // Hold at 255 rather than wrapping so long illegal runs stay visible.
         if (r_count != 8'hFF)
            r_count <= r_count + 8'd1;
      end
   end

   assign o_seen  = r_seen;
   assign o_count = r_count;

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder: opcode -> datapath strobes + ALUOp, zero-cycle combinational; no handshake.
// Status counters register unsupported opcodes; CONTROL_UNIT_JAL_EN adds JAL decode and the Jump port.
module control_unit
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   output logic       Branch,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrc,
   output logic [1:0] ALUOp,
   output logic       Illegal,
   output logic       illegal_seen,
   output logic [7:0] illegal_count
`ifdef CONTROL_UNIT_JAL_EN
   ,output logic      Jump
`endif
);

   ctrl_t w_ctrl;
   logic  w_illegal;

   always_comb begin
      w_ctrl    = '0;
      w_illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_ITYPE: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.alu_op    = ALUOP_FUNCT;
         end
         OP_LOAD: begin
            w_ctrl.mem_read   = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.alu_op     = ALUOP_ADD;
         end
         OP_STORE: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         OP_BRANCH: begin
            w_ctrl.branch = 1'b1;
            w_ctrl.alu_op = ALUOP_SUB;
         end
`ifdef CONTROL_UNIT_JAL_EN
         OP_JAL: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.jump      = 1'b1;
         end
`endif
         // Unsupported opcodes leave every strobe low so nothing is written.
         default: w_illegal = 1'b1;
      endcase
   end

   assign Branch   = w_ctrl.branch;
   assign MemRead  = w_ctrl.mem_read;
   assign MemWrite = w_ctrl.mem_write;
   assign MemtoReg = w_ctrl.mem_to_reg;
   assign RegWrite = w_ctrl.reg_write;
   assign ALUSrc   = w_ctrl.alu_src;
   assign ALUOp    = w_ctrl.alu_op;
   assign Illegal  = w_illegal;
`ifdef CONTROL_UNIT_JAL_EN
   assign Jump     = w_ctrl.jump;
`endif

   control_unit_status u_status (
      .clk       (clk),
      .rst       (rst),
      .i_illegal (w_illegal),
      .o_seen    (illegal_seen),
      .o_count   (illegal_count)
   );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: driver queues expected decode/status per cycle, monitor checks at negedge.
// Builds with or without CONTROL_UNIT_JAL_EN.
module tb_control_unit;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, Illegal;
   logic [1:0] ALUOp;
   logic       illegal_seen;
   logic [7:0] illegal_count;
`ifdef CONTROL_UNIT_JAL_EN
   logic       Jump;
`endif

   control_unit dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .Branch        (Branch),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .MemtoReg      (MemtoReg),
      .RegWrite      (RegWrite),
      .ALUSrc        (ALUSrc),
      .ALUOp         (ALUOp),
      .Illegal       (Illegal),
      .illegal_seen  (illegal_seen),
      .illegal_count (illegal_count)
`ifdef CONTROL_UNIT_JAL_EN
      ,.Jump         (Jump)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic [8:0] dec;   // {Branch,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrc,ALUOp,Illegal}
      logic       jmp;
      logic       seen;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Hand-written decode table.
   function automatic logic [9:0] exp_out(input logic [6:0] op);
      case (op)
         7'b0110011: return {9'b0000_1_0_10_0, 1'b0};
         7'b0010011: return {9'b0000_1_1_10_0, 1'b0};
         7'b0000011: return {9'b0101_1_1_00_0, 1'b0};
         7'b0100011: return {9'b0010_0_1_00_0, 1'b0};
         7'b1100011: return {9'b1000_0_0_01_0, 1'b0};
`ifdef CONTROL_UNIT_JAL_EN
         7'b1101111: return {9'b0000_1_0_00_0, 1'b1};
`endif
         default:    return {9'b0000_0_0_00_1, 1'b0};
      endcase
   endfunction

   logic       m_seen = 1'b0;
   logic [7:0] m_cnt  = 8'd0;
   logic       cur_rst;
   logic [6:0] cur_op;

   task automatic step(input logic [6:0] op, input logic r);
      logic [9:0] e;
      exp_t       x;
      @(posedge clk);
      e = exp_out(cur_op);
      if (cur_rst) begin
         m_seen = 1'b0;
         m_cnt  = 8'd0;
      end else if (e[1]) begin
         m_seen = 1'b1;
         if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
      #1;
      opcode  = op;
      rst     = r;
      cur_op  = op;
      cur_rst = r;
      e       = exp_out(op);
      x.op    = op;
      x.dec   = e[9:1];
      x.jmp   = e[0];
      x.seen  = m_seen;
      x.cnt   = m_cnt;
      exp_q.push_back(x);
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   initial begin
      exp_t       x;
      logic [8:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            act = {Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, ALUOp, Illegal};
            checks++;
            if (act !== x.dec) begin
               errors++;
               $display("FAIL decode op=%b got=%b want=%b", x.op, act, x.dec);
            end
            checks++;
            if (illegal_seen !== x.seen) begin
               errors++;
               $display("FAIL illegal_seen op=%b got=%b want=%b", x.op, illegal_seen, x.seen);
            end
            checks++;
            if (illegal_count !== x.cnt) begin
               errors++;
               $display("FAIL illegal_count op=%b got=%0d want=%0d", x.op, illegal_count, x.cnt);
            end
`ifdef CONTROL_UNIT_JAL_EN
            checks++;
            if (Jump !== x.jmp) begin
               errors++;
               $display("FAIL jump op=%b got=%b want=%b", x.op, Jump, x.jmp);
            end
`endif
         end
      end
   end

   initial begin
      logic [6:0] legal_ops [5];
      int         guard;
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
      rst     = 1'b1;
      opcode  = 7'b0110011;
      cur_rst = 1'b1;
      cur_op  = 7'b0110011;

      // Reset state, decode follows opcode during reset.
      step(7'b0110011, 1'b1);
      step(7'b0000011, 1'b1);
      step(7'b0110011, 1'b0);
      foreach (legal_ops[i]) step(legal_ops[i], 1'b0);

      // Three cycles of opcode 0, then count should read 3.
      step(7'b0110011, 1'b1);
      for (int i = 0; i < 3; i++) step(7'b0000000, 1'b0);
      step(7'b0110011, 1'b0);

      // JAL opcode (illegal unless the feature is built in).
      step(7'b1101111, 1'b0);
      step(7'b0010011, 1'b0);

      // Saturation: 300 illegal cycles.
      for (int i = 0; i < 300; i++) step(7'b1111111, 1'b0);
      step(7'b1111111, 1'b0);
      step(7'b0100011, 1'b0);

      // Reset held while opcode illegal.
      for (int i = 0; i < 4; i++) step(7'b0000001, 1'b1);
      step(7'b1100011, 1'b0);

      // Full opcode sweep.
      for (int i = 0; i < 128; i++) step(7'(i), 1'b0);
      step(7'b0110011, 1'b0);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Main decoder for the single-cycle RV32I datapath. It maps the 7-bit instruction opcode to the datapath control strobes and the 2-bit ALUOp consumed by the ALU-control block. Decode is purely combinational. A clocked status section records unsupported opcodes for debug.

## Interface
- No parameters.
- clk  in  1  system clock; clocks only the status registers.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  7  instruction bits [6:0].
- Branch  out  1  conditional-branch instruction.
- MemRead  out  1  data-memory read enable.
- MemWrite  out  1  data-memory write enable.
- MemtoReg  out  1  1 = write-back from memory, 0 = from ALU.
- RegWrite  out  1  register-file write enable.
- ALUSrc  out  1  1 = immediate operand B, 0 = rs2.
- ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = decode funct3/funct7.
- Illegal  out  1  current opcode is unsupported (combinational).
- illegal_seen  out  1  sticky flag: an unsupported opcode was sampled.
- illegal_count  out  8  saturating count of cycles with an unsupported opcode.
- Jump  out  1  JAL decoded. Present only with CONTROL_UNIT_JAL_EN.

## Operation
Decode, as Branch/MemRead/MemWrite/MemtoReg/RegWrite/ALUSrc/ALUOp:
- 0110011 R-type: 0/0/0/0/1/0/10
- 0010011 I-type ALU: 0/0/0/0/1/1/10
- 0000011 load: 0/1/0/1/1/1/00
- 0100011 store: 0/0/1/0/0/1/00
- 1100011 branch: 1/0/0/0/0/0/01
- Any other opcode, including 0000000 and opcodes with bits[1:0] ≠ 11:
  - All strobes are 0 and ALUOp is 00.
  - Illegal is 1.
  - No memory write or register write ever occurs.
- Illegal is 0 for every supported opcode.
- Status registers, updated every clk edge:
  - illegal_seen is set when Illegal = 1. It holds until rst.
  - illegal_count increments when Illegal = 1 and saturates at 255, with no wrap.

## Timing
- Decode outputs and Illegal have zero-cycle latency, combinational from opcode. There are no latches, and every case assigns every output.
- rst does not affect the decode outputs. They follow opcode during reset.
- rst = 1 at an edge: illegal_seen goes to 0 and illegal_count goes to 0. Reset wins over a simultaneous illegal opcode.
- Status registers update one edge after an illegal opcode is presented. An illegal opcode held for N edges adds min(N, 255 − count).
- No handshake is involved. opcode must be stable only by the end of each cycle, for status sampling.

## Configuration
- CONTROL_UNIT_JAL_EN defined:
  - Adds the Jump output.
  - Opcode 1101111 decodes to RegWrite = 1 and Jump = 1. All other strobes are 0, ALUOp is 00, and Illegal is 0.
  - Jump is 0 for all other opcodes.
- Macro undefined:
  - There is no Jump port.
  - 1101111 is illegal: all outputs are 0, Illegal = 1, and the status counters advance.

## Structure
- Shared package riscv_pkg holds:
  - Opcode constants: OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL.
  - ALUOp constants: ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10.
  - A packed struct typedef ctrl_t bundling the strobes.
- One natural sub-module is control_unit_status, containing the sticky flag and the saturating counter. The decoder stays a single always_comb case.

## Test plan
- Opcodes 0110011, 0010011, 0000011, 0100011, 1100011, each applied in turn -> outputs match the decode list exactly, with Illegal = 0.
- opcode = 0000000 for 3 cycles after reset -> all strobes 0, ALUOp 00, Illegal 1. After the 3 edges, illegal_seen = 1 and illegal_count = 3.
- opcode = 1101111 without the macro -> Illegal = 1 and all strobes 0. With CONTROL_UNIT_JAL_EN -> RegWrite = 1, Jump = 1, Illegal = 0, counters unchanged.
- Illegal opcode held for 300 cycles -> illegal_count stops at 255 and does not wrap.
- rst = 1 while opcode is illegal -> counters go to 0 and stay 0 while rst is held. Decode outputs continue to follow opcode.
- Random opcode sweep (all 128 values) -> MemWrite = 1 only for 0100011, and Illegal = 1 exactly for unsupported values.
